execute_cycle: RTL
==================

# execute_cycle

Execute stage of the 5-stage RISC-V core and the consumer of the ID/EX bundle the decode stage registers.
- Selects forwarded operands, computes the ALU result, resolves `beq` and computes the branch target.
- Holds the EX/MEM pipeline register that feeds the memory stage.
- Branch redirect (`PCSrc_E`, `PCTarget_E`) is combinational back to fetch. All `_M` outputs are registered.

## Interface
Parameters:
- `XLEN`, 32, datapath width.

Ports. Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `Valid_E`  in  1  ID/EX slot holds a real instruction.
- `RegWrite_E`, `ALUSrc_E`, `MemWrite_E`, `ResultSrc_E`, `Branch_E`  in  1 each  control from ID/EX.
- `ALUControl_E`  in  3  ALU operation.
- `RD1_E`, `RD2_E`, `Imm_Ext_E`, `PC_E`, `PCPlus4_E`  in  XLEN each  operands and PCs from ID/EX.
- `Rd_E`  in  5  destination register.
- `ForwardA_E`, `ForwardB_E`  in  2 each  operand select from hazard unit.
- `Result_W`  in  XLEN  writeback-stage result, used for forwarding.
- `Stall_M`  in  1  hold the EX/MEM register.
- `Flush_M`  in  1  insert a bubble into the EX/MEM register.
- `PCSrc_E`  out  1  take branch.
- `PCTarget_E`  out  XLEN  branch target, `PC_E + Imm_Ext_E`.
- `Valid_M`, `RegWrite_M`, `MemWrite_M`, `ResultSrc_M`  out  1 each  registered control.
- `ALUResult_M`, `WriteData_M`, `PCPlus4_M`  out  XLEN each  registered data.
- `Rd_M`  out  5  registered destination register.

## Operation
- **Operand A (`ForwardA_E`):**
  - `00` → `RD1_E`
  - `01` → `Result_W`
  - `10` → `ALUResult_M` (own registered output)
  - `11` → `RD1_E` (reserved)
- **Forwarded B (`ForwardB_E`):** same encoding, applied to `RD2_E`. Forwarded B is the store data (`WriteData`).
- **Operand B:** `ALUSrc_E ? Imm_Ext_E : forwarded B`.
- **ALU (`ALUControl_E`):**
  - `000` add, `001` sub, `010` and, `011` or, `101` slt (signed; result 1 or 0, zero-extended).
  - Any other code gives result 0.
  - Arithmetic wraps modulo 2^XLEN. No overflow flag.
- **Zero:** `Zero = (result == 0)`.
- **Branch:** `PCSrc_E = Valid_E & Branch_E & Zero`. `PCTarget_E` is a wrapping add and is always driven, regardless of `Valid_E`.
- **EX/MEM register, evaluated at the clock edge in priority order:**
  1. `Flush_M` → bubble: all `_M` control bits 0, `Valid_M` 0; data fields 0.
  2. `Stall_M` → all `_M` outputs hold.
  3. Otherwise → load.
- **Load values:**
  - `Valid_M`, `RegWrite_M`, `MemWrite_M` load `Valid_E` ANDed with their source. An invalid slot never writes.
  - `ResultSrc_M` loads `ResultSrc_E`.
  - Data fields load unconditionally.

## Timing
- **Reset:** `rst` low clears every `_M` output to 0 immediately, with no clock needed. The clear holds while `rst` is low. First load happens on the first rising edge after release.
- **Combinational paths:** `PCSrc_E` and `PCTarget_E` settle in the same cycle as their ID/EX inputs. No registers on these paths.
- **Latency:** 1 cycle from ID/EX inputs to `_M` outputs.
- **Back-to-back dependency:** with `ForwardA_E = 10`, cycle N+1 uses the result registered at the edge ending cycle N.
- **`Stall_M` and `Flush_M` together:** flush wins.
- **Stall with forward select `10`:** the held `ALUResult_M` is the value used.
- **Reset mid-stall:** the stall is dropped. Outputs are 0 after reset.

## Structure
- **Package `riscv_pkg`:**
  - ALU op constants: `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`.
  - Forward select constants: `FWD_RF`, `FWD_WB`, `FWD_MEM`.
  - `XLEN` default.
- **Sub-module `alu`:** combinational, with ports `a`, `b`, `ALUControl`, `Result`, `Zero`. It is instantiated once.
- **In this block:** forwarding muxes, branch adder and the EX/MEM register stay here.

## Test plan
1. **Reset:** assert `rst = 0` mid-cycle with the EX/MEM register loaded → all `_M` outputs equal 0 before the next edge.
2. **Add / sub:**
   - `RD1 = 5`, `RD2 = 7`, add, `ALUSrc = 0` → `ALUResult_M = 12` one cycle later.
   - sub with `RD1 = 3`, `RD2 = 5` → `0xFFFFFFFE`.
   - slt with `RD1 = -1`, `RD2 = 1` → 1.
3. **Taken branch:** `Branch_E = 1`, `RD1 = RD2 = 9`, sub, `PC_E = 0x100`, `Imm = 0x20` → `PCSrc_E = 1` and `PCTarget_E = 0x120` in the same cycle.
4. **Invalid branch:** repeat scenario 3 with `Valid_E = 0` → `PCSrc_E = 0`, and `RegWrite_M = 0` after the edge.
5. **Forwarding:** first instruction adds `10 + 1`; the next uses `ForwardA = 10` with `RD1 = 0`, `Imm = 4`, `ALUSrc = 1` → `ALUResult_M = 15`. Next, `ForwardB = 01` with `Result_W = 0x55` and a store → `WriteData_M = 0x55`.
6. **Stall and flush:**
   - `Stall_M` for 2 cycles while inputs change → `_M` outputs unchanged.
   - `Stall_M` and `Flush_M` together → `Valid_M = 0`, `RegWrite_M = 0`, `MemWrite_M = 0`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core pipeline: datapath width, ALU opcodes
// and forwarding-select encodings.
package riscv_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage; undefined opcodes produce zero.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  logic slt_bit;

  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = a + b;
      ALU_SUB: Result = a - b;
      ALU_AND: Result = a & b;
      ALU_OR:  Result = a | b;
      ALU_SLT: Result = {{(XLEN-1){1'b0}}, slt_bit};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution with combinational
// redirect to fetch, and the EX/MEM pipeline register.
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Valid_E,
  input  logic            RegWrite_E,
  input  logic            ALUSrc_E,
  input  logic            MemWrite_E,
  input  logic            ResultSrc_E,
  input  logic            Branch_E,
  input  logic [2:0]      ALUControl_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PC_E,
  input  logic [XLEN-1:0] PCPlus4_E,
  input  logic [4:0]      Rd_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] Result_W,
  input  logic            Stall_M,
  input  logic            Flush_M,
  output logic            PCSrc_E,
  output logic [XLEN-1:0] PCTarget_E,
  output logic            Valid_M,
  output logic            RegWrite_M,
  output logic            MemWrite_M,
  output logic            ResultSrc_M,
  output logic [XLEN-1:0] ALUResult_M,
  output logic [XLEN-1:0] WriteData_M,
  output logic [XLEN-1:0] PCPlus4_M,
  output logic [4:0]      Rd_M
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
  logic            alu_zero;

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_write_q, mem_write_d;
  logic            result_src_q, result_src_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [4:0]      rd_q, rd_d;

  // The MEM-stage forward taps our own register, so a held value is what a
  // stalled consumer sees.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      FWD_WB:  src_a = Result_W;
      FWD_MEM: src_a = alu_result_q;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      FWD_WB:  fwd_b = Result_W;
      FWD_MEM: fwd_b = alu_result_q;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrc_E ? Imm_Ext_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .a          (src_a),
    .b          (src_b),
    .ALUControl (ALUControl_E),
    .Result     (alu_result),
    .Zero       (alu_zero)
  );

  assign PCSrc_E    = Valid_E & Branch_E & alu_zero;
  assign PCTarget_E = PC_E + Imm_Ext_E;

  // Flush outranks stall; write enables are gated by Valid_E so a bubble
  // arriving from decode can never commit.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    if (Flush_M) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = 1'b0;
      alu_result_d = '0;
      write_data_d = '0;
      pc_plus4_d   = '0;
      rd_d         = '0;
    end else if (!Stall_M) begin
      valid_d      = Valid_E;
      reg_write_d  = Valid_E & RegWrite_E;
      mem_write_d  = Valid_E & MemWrite_E;
      result_src_d = ResultSrc_E;
      alu_result_d = alu_result;
      write_data_d = fwd_b;
      pc_plus4_d   = PCPlus4_E;
      rd_d         = Rd_E;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
      rd_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
    end
  end

  assign Valid_M     = valid_q;
  assign RegWrite_M  = reg_write_q;
  assign MemWrite_M  = mem_write_q;
  assign ResultSrc_M = result_src_q;
  assign ALUResult_M = alu_result_q;
  assign WriteData_M = write_data_q;
  assign PCPlus4_M   = pc_plus4_q;
  assign Rd_M        = rd_q;

endmodule
